spi_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `spi_master` between `NUM_REQ` requesters. It accepts level requests, issues one single-word SPI transfer per grant by pulsing the master's `spi_start`, and returns the received word to the granted requester with a one-cycle acknowledge. A watchdog aborts any transfer whose `spi_done` never arrives. It sits directly in front of `spi_master`, and its `m_*` ports connect 1:1 to that module's user-side ports.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_rr_pick.sv | 30 +++
 rtl/spi_arbiter.sv | 139 +++++++++++++
 tb/tb_spi_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI arbiter slice: FSM state encoding and a
// width helper used for the grant index and watchdog counter.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Bits needed to hold 0..n-1, never narrower than one bit.
    function automatic int spi_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin pick: first eligible requester found scanning
// upward from last_grant+1, wrapping modulo NUM_REQ.
module spi_rr_pick
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int GW = spi_clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [GW-1:0]      last_grant,
    output logic               valid,
    output logic [GW-1:0]      winner
);

    // Walk from the farthest offset down so the nearest eligible one is written last.
    always_comb begin
        int idx;
        idx    = 0;
        valid  = 1'b0;
        winner = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (eligible[idx[GW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sequencer sharing one spi_master between NUM_REQ requesters,
// with a WAIT-state watchdog that aborts transfers whose done never comes.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int GW = spi_clog2(NUM_REQ),
    localparam int CW = spi_clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [GW-1:0]                 grant_id,
    output logic                          m_start,
    output logic [DATA_WIDTH-1:0]         m_data_send,
    input  logic                          m_done,
    input  logic [DATA_WIDTH-1:0]         m_data_recv
);

    localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [GW-1:0]           grant_id_q, grant_id_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]   data_send_q, data_send_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic                    start_q, start_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    holdoff_q, holdoff_d;
    logic [CW-1:0]           wdog_q, wdog_d;
    logic [NUM_REQ-1:0]      holdoff_mask;
    logic [NUM_REQ-1:0]      eligible;
    logic                    pick_valid;
    logic [GW-1:0]           pick_id;

    // Requesters may drop req one cycle after ack, so the just-served one is masked once.
    assign holdoff_mask = holdoff_q ? (NUM_REQ'(1) << last_grant_q) : '0;
    assign eligible     = req & ~holdoff_mask;

    spi_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .eligible  (eligible),
        .last_grant(last_grant_q),
        .valid     (pick_valid),
        .winner    (pick_id)
    );

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        data_send_d  = data_send_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        ack_d        = '0;
        start_d      = 1'b0;
        holdoff_d    = 1'b0;
        wdog_d       = wdog_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_id_d  = pick_id;
                    data_send_d = req_data[int'(pick_id)*DATA_WIDTH +: DATA_WIDTH];
                    start_d     = 1'b1;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wdog_q != '1) wdog_d = wdog_q + 1'b1;
                // A done arriving on the expiry cycle takes priority over the timeout.
                if (m_done) begin
                    rsp_data_d        = m_data_recv;
                    rsp_err_d         = 1'b0;
                    ack_d[grant_id_q] = 1'b1;
                    state_d           = ST_RESP;
                end else if (TIMEOUT_CYCLES != 0 && wdog_q == WDOG_LAST) begin
                    rsp_data_d        = '0;
                    rsp_err_d         = 1'b1;
                    ack_d[grant_id_q] = 1'b1;
                    state_d           = ST_RESP;
                end
            end
            ST_RESP: begin
                last_grant_d = grant_id_q;
                holdoff_d    = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            data_send_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            ack_q        <= '0;
            start_q      <= 1'b0;
            holdoff_q    <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            data_send_q  <= data_send_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            ack_q        <= ack_d;
            start_q      <= start_d;
            holdoff_q    <= holdoff_d;
            wdog_q       <= wdog_d;
        end
    end

    assign ack         = ack_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = grant_id_q;
    assign m_start     = start_q;
    assign m_data_send = data_send_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: a behavioural spi_master stand-in plus a service-order
// model (pending set, round-robin pointer) predicting every grant and response.
`timescale 1ns/1ps
module tb_spi_arbiter;

    localparam int N            = 4;
    localparam int DW           = 8;
    localparam int TMO          = 16;
    // Shorter than the watchdog so ordinary transfers complete normally.
    localparam int NORMAL_DELAY = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            busy;
    logic [1:0]      grant_id;
    logic            m_start;
    logic [DW-1:0]   m_data_send;
    logic            m_done = 1'b0;
    logic [DW-1:0]   m_data_recv = '0;

    int testsRun    = 0;
    int testsFailed = 0;

    spi_arbiter #(
        .NUM_REQ       (N),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .grant_id   (grant_id),
        .m_start    (m_start),
        .m_data_send(m_data_send),
        .m_done     (m_done),
        .m_data_recv(m_data_recv)
    );

    always #5 clk = ~clk;

    // Master stand-in: done mdl_delay cycles after start, echoing the inverted word.
    int            mdl_delay   = NORMAL_DELAY;
    bit            mdl_done_en = 1'b1;
    int            mdl_cnt     = 0;
    bit            mdl_active  = 1'b0;
    logic [DW-1:0] mdl_word    = '0;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (m_start) begin
            mdl_active <= 1'b1;
            mdl_cnt    <= 1;
            mdl_word   <= ~m_data_send;
        end else if (mdl_active) begin
            if (mdl_cnt == mdl_delay - 1) begin
                m_done      <= mdl_done_en;
                m_data_recv <= mdl_word;
                mdl_active  <= 1'b0;
            end
            mdl_cnt <= mdl_cnt + 1;
        end
    end

    logic [N-1:0] pending;
    logic [N-1:0] holders;
    int           last_grant;
    int           cur_grant;
    int           start_cycle;
    int           cycle_no;
    int           ack_count;
    bit           in_xfer;
    bit           prev_start;
    bit           idle_next;
    bit           exp_timeout;
    int           drop_cnt [N];

    function automatic int rr_next(input logic [N-1:0] set, input int last);
        for (int k = 1; k <= N; k++) begin
            if (set[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] slice_of(input int i);
        return req_data[i*DW +: DW];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] mask, input logic [N-1:0] hold, input logic [N*DW-1:0] data);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                req_data[i*DW +: DW] = data[i*DW +: DW];
                req[i]               = 1'b1;
            end
        end
        pending = pending | mask;
        holders = holders | hold;
    endtask

    task automatic resetModel();
        pending    = '0;
        holders    = '0;
        in_xfer    = 1'b0;
        idle_next  = 1'b0;
        prev_start = 1'b0;
        last_grant = N - 1;
        req        = '0;
        for (int i = 0; i < N; i++) drop_cnt[i] = 0;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_grant_id", grant_id, 0);
        checkOutput("rst_m_start", m_start, 0);
        checkOutput("rst_m_data_send", m_data_send, 0);
    endtask

    // One clock of the requester side: lagged drops, then all observations.
    task automatic tick();
        int            exp_id;
        logic [DW-1:0] exp_rsp;
        @(posedge clk);
        #1;
        cycle_no++;
        for (int i = 0; i < N; i++) begin
            if (drop_cnt[i] > 0) begin
                drop_cnt[i]--;
                if (drop_cnt[i] == 0) req[i] = 1'b0;
            end
        end
        if (idle_next) begin
            checkOutput("busy_after_resp", busy, 0);
            idle_next = 1'b0;
        end
        if (m_start) begin
            checkOutput("m_start_one_cycle", prev_start, 0);
            exp_id = rr_next(pending, last_grant);
            if (exp_id < 0 || in_xfer) begin
                checkOutput("unexpected_m_start", m_start, 0);
            end else begin
                checkOutput("grant_id", grant_id, exp_id);
                checkOutput("m_data_send", m_data_send, slice_of(exp_id));
                checkOutput("busy_at_start", busy, 1);
                cur_grant   = exp_id;
                start_cycle = cycle_no;
                in_xfer     = 1'b1;
            end
        end
        if (ack != '0) begin
            if (!in_xfer) begin
                checkOutput("unexpected_ack", ack, 0);
            end else begin
                exp_rsp = exp_timeout ? '0 : ~slice_of(cur_grant);
                checkOutput("ack_onehot", ack, 1 << cur_grant);
                checkOutput("rsp_data", rsp_data, exp_rsp);
                checkOutput("rsp_err", rsp_err, exp_timeout);
                checkOutput("ack_latency", cycle_no - start_cycle, exp_timeout ? TMO + 1 : mdl_delay + 1);
                checkOutput("m_data_send_hold", m_data_send, slice_of(cur_grant));
                checkOutput("busy_at_resp", busy, 1);
                last_grant = cur_grant;
                in_xfer    = 1'b0;
                idle_next  = 1'b1;
                ack_count++;
                if (!holders[cur_grant]) begin
                    pending[cur_grant]  = 1'b0;
                    drop_cnt[cur_grant] = 2;
                end
            end
        end
        prev_start = m_start;
    endtask

    task automatic drainAll(input int budget);
        int used;
        used = 0;
        while ((pending != '0 || in_xfer) && used < budget) begin
            tick();
            used++;
        end
        checkOutput("drain_within_budget", (pending == '0 && !in_xfer), 1);
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic runAcks(input int target, input int budget);
        int used;
        int goal;
        used = 0;
        goal = ack_count + target;
        while (ack_count < goal && used < budget) begin
            tick();
            used++;
        end
        checkOutput("acks_within_budget", ack_count >= goal, 1);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        checkResetValues();
        rst = 1'b0;
        resetModel();
    endtask

    initial begin
        int used;
        int acks_before;
        rst         = 1'b1;
        req_data    = '0;
        cycle_no    = 0;
        ack_count   = 0;
        exp_timeout = 1'b0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkResetValues();
        rst = 1'b0;

        // Single request from requester 0, also exercising the lagged drop.
        applyStimulus(4'b0001, 4'b0000, {24'h0, 8'hA5});
        drainAll(200);
        checkOutput("single_ack_count", ack_count, 1);

        // All four at once right after reset: served 0,1,2,3.
        pulseReset();
        acks_before = ack_count;
        applyStimulus(4'hF, 4'b0000, 32'($urandom));
        drainAll(400);
        checkOutput("all_four_ack_count", ack_count - acks_before, 4);

        // Two requesters holding req continuously must alternate.
        applyStimulus(4'b0101, 4'b0101, 32'($urandom));
        runAcks(6, 400);
        req     = req & ~holders;
        pending = pending & ~holders;
        holders = '0;
        drainAll(200);

        // Requester 1 alone, dropping one cycle after its ack.
        applyStimulus(4'b0010, 4'b0000, 32'($urandom));
        drainAll(200);

        for (int t = 0; t < 6; t++) begin
            applyStimulus(4'($urandom_range(1, 15)), 4'b0000, 32'($urandom));
            drainAll(500);
        end

        // Watchdog expiry with no done, then done landing on the expiry cycle.
        mdl_done_en = 1'b0;
        exp_timeout = 1'b1;
        applyStimulus(4'b1000, 4'b0000, 32'($urandom));
        drainAll(200);
        mdl_done_en = 1'b1;
        exp_timeout = 1'b0;
        mdl_delay   = TMO;
        applyStimulus(4'b0100, 4'b0000, 32'($urandom));
        drainAll(200);
        mdl_delay = NORMAL_DELAY;

        // Reset in the middle of WAIT; the late done must be ignored.
        applyStimulus(4'b0010, 4'b0000, 32'($urandom));
        used = 0;
        while (!(in_xfer && (cycle_no - start_cycle) >= 5) && used < 50) begin
            tick();
            used++;
        end
        checkOutput("reached_wait_before_reset", in_xfer, 1);
        pulseReset();
        for (int k = 0; k < 25; k++) tick();
        acks_before = ack_count;
        applyStimulus(4'hF, 4'b0000, 32'($urandom));
        drainAll(400);
        checkOutput("post_reset_ack_count", ack_count - acks_before, 4);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_time_limit: observed still running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
